// File: rtl/char_buffer_arbiter.sv
// Single write port into the row-major character RAM: a clear engine plus two round-robin requesters.
// Optional macro CHARBUF_FILL_CHAR_EN adds a fill_char input latched by clr_req for the clear engine.
module char_buffer_arbiter #(
  parameter int COLS   = 64,
  parameter int ROWS   = 11,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_req,
  input  logic [3:0]        clr_first,
  input  logic [3:0]        clr_last,
`ifdef CHARBUF_FILL_CHAR_EN
  input  logic [7:0]        fill_char,
`endif
  output logic              clr_busy,
  output logic              clr_done,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [7:0]        req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [7:0]        req1_data,
  output logic              req1_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              err
);

  localparam int CSH = $clog2(COLS);
  localparam logic [ADDR_W:0] NCHAR = (ADDR_W+1)'(COLS * ROWS);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] end_addr;
  logic [7:0]        fill_q;
  logic              last_grant;
  logic              range_ok;
  logic              grant;
  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]        sel_data;
  logic              in_range;

  assign range_ok = (clr_first <= clr_last) && (32'(clr_last) < ROWS);
  assign grant    = req0_ready | req1_ready;
  assign sel_addr = req1_ready ? req1_addr : req0_addr;
  assign sel_data = req1_ready ? req1_data : req0_data;
  assign in_range = {1'b0, sel_addr} < NCHAR;
  assign clr_busy = (state != IDLE);
  assign clr_done = (state == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Readies are gated by reset so they read 0 while reset is held, even with valids high.
  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt = range_ok ? CLEAR : DONE;
        end else if (reset) begin
          req0_ready = req0_valid && (!req1_valid || last_grant);
          req1_ready = req1_valid && (!req0_valid || !last_grant);
        end
      end
      CLEAR: begin
        if (ptr == end_addr) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr        <= '0;
      end_addr   <= '0;
      fill_q     <= 8'h20;
      last_grant <= 1'b1;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      err        <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_req) begin
            if (range_ok) begin
              ptr      <= ADDR_W'({clr_first, {CSH{1'b0}}});
              end_addr <= ADDR_W'({clr_last, {CSH{1'b1}}});
`ifdef CHARBUF_FILL_CHAR_EN
              fill_q   <= fill_char;
`else
              fill_q   <= 8'h20;
`endif
            end else begin
              err <= 1'b1;
            end
          end else if (grant) begin
            last_grant <= req1_ready;
            // Out-of-range writes are consumed but dropped, so the requester never stalls.
            if (in_range) begin
              wr_en   <= 1'b1;
              wr_addr <= sel_addr;
              wr_data <= sel_data;
            end else begin
              err <= 1'b1;
            end
          end
        end
        CLEAR: begin
          wr_en   <= 1'b1;
          wr_addr <= ptr;
          wr_data <= fill_q;
          ptr     <= ptr + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_char_buffer_arbiter.sv
// Directed bench for char_buffer_arbiter: arbitration, clears, range errors, reset mid-clear.
module tb_char_buffer_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clr_req = 1'b0;
  logic [3:0] clr_first = '0, clr_last = '0;
`ifdef CHARBUF_FILL_CHAR_EN
  logic [7:0] fill_char = '0;
`endif
  logic       clr_busy, clr_done;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [9:0] req0_addr = '0, req1_addr = '0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic       req0_ready, req1_ready;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic       err;
  int total = 0;
  int bad = 0;

  char_buffer_arbiter dut (
    .clk(clk), .reset(reset),
    .clr_req(clr_req), .clr_first(clr_first), .clr_last(clr_last),
`ifdef CHARBUF_FILL_CHAR_EN
    .fill_char(fill_char),
`endif
    .clr_busy(clr_busy), .clr_done(clr_done),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic all_zero(input string tag);
    check({tag, "_wr_en"}, 32'(wr_en), 0);
    check({tag, "_wr_addr"}, 32'(wr_addr), 0);
    check({tag, "_wr_data"}, 32'(wr_data), 0);
    check({tag, "_busy"}, 32'(clr_busy), 0);
    check({tag, "_done"}, 32'(clr_done), 0);
    check({tag, "_err"}, 32'(err), 0);
    check({tag, "_rdy0"}, 32'(req0_ready), 0);
    check({tag, "_rdy1"}, 32'(req1_ready), 0);
  endtask

  task automatic do_reset();
    clr_req = 0; req0_valid = 0; req1_valid = 0;
    reset = 0;
    next_cycle();
    check("rst_err", 32'(err), 0);
    reset = 1;
  endtask

  initial begin
    // Reset state, valids held high to show readies are forced low.
    req0_valid = 1; req0_addr = 10'd5; req0_data = 8'h30;
    req1_valid = 1; req1_addr = 10'd6; req1_data = 8'h31;
    @(negedge clk);
    all_zero("reset");
    next_cycle();
    reset = 1;

    // Round robin with both valid: 0,1,0,1; writes one cycle later.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rr_rdy0", 32'(req0_ready), 32'(i % 2 == 0));
      check("rr_rdy1", 32'(req1_ready), 32'(i % 2 == 1));
      if (i > 0) begin
        check("rr_wr_en", 32'(wr_en), 1);
        check("rr_wr_addr", 32'(wr_addr), (i % 2 == 1) ? 32'd5 : 32'd6);
      end
      next_cycle();
    end
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    check("rr_tail_en", 32'(wr_en), 1);
    check("rr_tail_addr", 32'(wr_addr), 6);
    check("rr_tail_data", 32'(wr_data), 32'h31);
    check("rr_idle_rdy0", 32'(req0_ready), 0);
    next_cycle();
    @(negedge clk);
    check("rr_idle_en", 32'(wr_en), 0);
    next_cycle();

    // Clear rows 2..3 while req0 waits; a stray invalid clr_req mid-clear must be ignored.
    clr_req = 1; clr_first = 4'd2; clr_last = 4'd3;
    req0_valid = 1; req0_addr = 10'd7; req0_data = 8'h42;
    @(negedge clk);
    check("clr0_rdy0", 32'(req0_ready), 0);
    check("clr0_busy", 32'(clr_busy), 0);
    next_cycle();
    clr_req = 0;
    for (int c = 1; c <= 129; c++) begin
      @(negedge clk);
      check("clr_busy", 32'(clr_busy), 1);
      check("clr_rdy0", 32'(req0_ready), 0);
      check("clr_wr_en", 32'(wr_en), 32'(c >= 2));
      if (c >= 2) begin
        check("clr_addr", 32'(wr_addr), 32'(128 + c - 2));
        check("clr_data", 32'(wr_data), 32'h20);
      end
      check("clr_done", 32'(clr_done), 32'(c == 129));
      next_cycle();
      clr_req = (c == 49);
      clr_first = 4'd7; clr_last = 4'd4;
    end
    @(negedge clk);
    check("post_busy", 32'(clr_busy), 0);
    check("post_done", 32'(clr_done), 0);
    check("post_rdy0", 32'(req0_ready), 1);
    check("post_wr_en", 32'(wr_en), 0);
    check("post_err", 32'(err), 0);
    next_cycle();
    req0_valid = 0;
    @(negedge clk);
    check("post_wr", 32'(wr_en), 1);
    check("post_addr", 32'(wr_addr), 7);
    check("post_data", 32'(wr_data), 32'h42);
    next_cycle();

    // Invalid ranges: first > last, then last >= ROWS.
    for (int k = 0; k < 2; k++) begin
      do_reset();
      clr_req = 1;
      clr_first = (k == 0) ? 4'd7 : 4'd0;
      clr_last  = (k == 0) ? 4'd4 : 4'd11;
      @(negedge clk);
      check("bad_err_pre", 32'(err), 0);
      next_cycle();
      clr_req = 0;
      @(negedge clk);
      check("bad_done", 32'(clr_done), 1);
      check("bad_busy", 32'(clr_busy), 1);
      check("bad_err", 32'(err), 1);
      check("bad_wr_en", 32'(wr_en), 0);
      next_cycle();
      @(negedge clk);
      check("bad_done_end", 32'(clr_done), 0);
      check("bad_wr_en2", 32'(wr_en), 0);
      repeat (3) next_cycle();
      check("bad_err_sticky", 32'(err), 1);
    end

    // Out-of-range requester address.
    do_reset();
    req1_valid = 1; req1_addr = 10'd704; req1_data = 8'h41;
    @(negedge clk);
    check("oob_rdy1", 32'(req1_ready), 1);
    next_cycle();
    req1_valid = 0;
    @(negedge clk);
    check("oob_wr_en", 32'(wr_en), 0);
    check("oob_err", 32'(err), 1);
    next_cycle();

    // Reset during a full clear after 100 writes, then a clean restart.
    do_reset();
    clr_req = 1; clr_first = 4'd0; clr_last = 4'd10;
    next_cycle();
    clr_req = 0;
    for (int c = 1; c <= 101; c++) begin
      @(negedge clk);
      if (c < 101) next_cycle();
    end
    check("mid_wr_en", 32'(wr_en), 1);
    check("mid_addr", 32'(wr_addr), 99);
    #1 reset = 0;
    #1 all_zero("midrst");
    next_cycle();
    reset = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("abandon_done", 32'(clr_done), 0);
      check("abandon_busy", 32'(clr_busy), 0);
      next_cycle();
    end
    clr_req = 1; clr_first = 4'd0; clr_last = 4'd0;
    next_cycle();
    clr_req = 0;
    for (int c = 1; c <= 65; c++) begin
      @(negedge clk);
      if (c == 1) check("restart_wr0", 32'(wr_en), 0);
      if (c == 2) begin
        check("restart_en", 32'(wr_en), 1);
        check("restart_addr", 32'(wr_addr), 0);
        check("restart_data", 32'(wr_data), 32'h20);
      end
      if (c == 65) begin
        check("restart_done", 32'(clr_done), 1);
        check("restart_last", 32'(wr_addr), 63);
      end
      next_cycle();
    end

`ifdef CHARBUF_FILL_CHAR_EN
    // Fill character latched at clr_req; changing it afterwards has no effect.
    do_reset();
    fill_char = 8'h2A; clr_req = 1; clr_first = 4'd10; clr_last = 4'd10;
    next_cycle();
    clr_req = 0; fill_char = 8'h00;
    for (int c = 1; c <= 65; c++) begin
      @(negedge clk);
      check("fill_wr_en", 32'(wr_en), 32'(c >= 2));
      if (c >= 2) begin
        check("fill_addr", 32'(wr_addr), 32'(640 + c - 2));
        check("fill_data", 32'(wr_data), 32'h2A);
      end
      check("fill_done", 32'(clr_done), 32'(c == 65));
      next_cycle();
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/char_buffer_arbiter.md
Name: char_buffer_arbiter

Overview:
Sequences all writes into the 704-byte display character RAM (11 rows x 64 columns, row-major, byte address = row*64 + col). Two requesters share the single RAM write port under round-robin arbitration:
- req0: the decoder line writer.
- req1: the status/message writer.
A built-in clear engine fills a row range with blank characters and has priority over both requesters. The block sits between the text producers and the character RAM that feeds the VGA text renderer.

Parameters:
COLS, 64, characters per row (power of two)
ROWS, 11, rows in the buffer
ADDR_W, 10, byte-address width; must satisfy 2^ADDR_W >= COLS*ROWS

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
clr_req  in  1  one-cycle request to clear rows clr_first..clr_last
clr_first  in  4  first row to clear
clr_last  in  4  last row to clear (inclusive)
clr_busy  out  1  clear engine active
clr_done  out  1  one-cycle pulse when a clear finishes or is rejected
req0_valid  in  1  requester 0 has a write
req0_addr  in  ADDR_W  requester 0 byte address
req0_data  in  8  requester 0 character
req0_ready  out  1  requester 0 write accepted this cycle
req1_valid, req1_addr, req1_data, req1_ready  same as requester 0, for requester 1
wr_en  out  1  RAM write strobe
wr_addr  out  ADDR_W  RAM write address
wr_data  out  8  RAM write data
err  out  1  sticky error flag

Behaviour:
- Reset (reset=0, asynchronous) forces every output to 0:
  - wr_en, wr_addr, wr_data, clr_busy, clr_done, err, req0_ready, req1_ready.
  - Also: state=IDLE, clear pointer=0, last_grant=1 (so req0 wins the first contention).
  - Asserting reset mid-clear abandons the clear; no clr_done is produced.
- FSM states:
  - IDLE: arbitrate requesters.
  - CLEAR: one blank write per cycle.
  - DONE: one cycle with clr_done=1, then IDLE.
- IDLE transitions:
  - clr_req=1 with a valid range (clr_first <= clr_last and clr_last < ROWS): load ptr = clr_first*COLS and go to CLEAR.
  - clr_req=1 with an invalid range: set err and go to DONE; no writes are issued.
  - In the cycle clr_req is taken, both readyN = 0 (clear has priority).
- clr_req outside IDLE is ignored. It is not queued and does not set err.
- CLEAR:
  - Each cycle: wr_en=1, wr_addr=ptr, wr_data=8'h20, then ptr++.
  - After the write to clr_last*COLS + COLS-1, go to DONE.
  - clr_busy=1 in CLEAR and DONE.
  - req0_ready = req1_ready = 0 throughout.
  - Clearing N rows takes exactly N*COLS write cycles, plus 1 cycle for DONE.
- Arbitration (IDLE, no clr_req):
  - readyN is combinational from state, valids and last_grant.
  - Only one valid: that requester is granted.
  - Both valid: the requester other than last_grant is granted.
  - last_grant updates only on a grant.
  - A transfer occurs when validN && readyN. The requester must hold addr/data stable while valid and not ready.
- Write latency: an accepted write appears on wr_en/wr_addr/wr_data on the next rising edge (one registered stage). wr_en=0 on cycles with no accepted or clear write.
- Out-of-range address (addr >= COLS*ROWS):
  - The request is still accepted (ready=1), so the requester never stalls.
  - No write is issued (wr_en stays 0) and err is set.
- err clears only on reset.
- Back-to-back: full rate, one write per cycle, no bubbles between grants or between the last clear write and the following requester grant, apart from the DONE cycle.

Optional Feature:
CHARBUF_FILL_CHAR_EN
- Defined: adds input port fill_char (8 bits). clr_req latches fill_char, and the clear engine writes the latched value instead of 8'h20.
- Undefined: no fill_char port; clear always writes 8'h20.

Test Plan:
- Reset then release; req0_valid=req1_valid=1 continuously with addr 5/6 -> grants alternate 0,1,0,1 starting with req0; wr_addr sequence 5,6,5,6, each one cycle after acceptance.
- clr_req with first=2, last=3 -> clr_busy high; 128 writes of 8'h20 at addresses 128..255, one per cycle; req readies 0 throughout; single clr_done pulse; then IDLE.
- clr_req with first=7, last=4; separately first=0, last=11 -> no wr_en, clr_done pulses once, err=1 and stays 1 until reset.
- req1_valid with addr 704, data 8'h41 -> req1_ready=1, wr_en stays 0, err=1.
- Assert reset during a clear of rows 0..10 after 100 writes -> all outputs 0 immediately; no clr_done; a fresh clr_req after release restarts cleanly at address 0.
- Macro defined: fill_char=8'h2A, clear row 10 -> 64 writes of 8'h2A at addresses 640..703.
